axil_i2c_regs: RTL

AXI-Lite slave register front end for the I2C bridge. It sits directly downstream of the testbench AXI-Lite bus (4-bit address, 32-bit data) and turns register accesses into the command, transmit-data and receive-data streams of the I2C master core. It also reports master status and holds the SCL prescale value. All storage is single-entry holding registers; there are no FIFOs.

---
 rtl/axil_i2c_regs_if.sv | 30 +++
 rtl/axil_i2c_regs.sv | 115 +++++++++++
 2 files changed

// File: rtl/axil_i2c_regs_if.sv
// axil_i2c_regs_if: AXI-Lite bus (4-bit address, 32-bit data) between host and register block
interface axil_i2c_regs_if;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_i2c_regs.sv
// axil_i2c_regs: AXI-Lite register front end for the I2C master command/tx/rx streams
module axil_i2c_regs #(
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd250
) (
  input  logic           clk,
  input  logic           rst,
  axil_i2c_regs_if.slave bus,
  output logic [6:0]     cmd_address,
  output logic           cmd_start,
  output logic           cmd_read,
  output logic           cmd_write,
  output logic           cmd_write_multiple,
  output logic           cmd_stop,
  output logic           cmd_valid,
  input  logic           cmd_ready,
  output logic [7:0]     data_out,
  output logic           data_out_last,
  output logic           data_out_valid,
  input  logic           data_out_ready,
  input  logic [7:0]     data_in,
  input  logic           data_in_last,
  input  logic           data_in_valid,
  output logic           data_in_ready,
  input  logic           busy,
  input  logic           bus_control,
  input  logic           bus_active,
  input  logic           missed_ack,
  output logic [15:0]    prescale
);
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_t;
  wr_t ws, ws_n;
  rd_t rs, rs_n;
  logic cmd_full, tx_full, rx_full, rx_last, sticky;
  logic [7:0] rx_byte;
  logic [1:0] wsel, rsel;
  logic we, re, cmd_wr, cmd_take, cmd_drop, tx_wr, tx_take, tx_drop, rx_cap, rx_pop, w1c;
  logic [31:0] status, rd_mux;
  logic unused;
  assign unused = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0], bus.wdata[31:16], bus.wstrb[3:2]};
  always_ff @(posedge clk) begin
    if (!rst) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
    end
  end
  always_comb begin
    ws_n = ws;
    rs_n = rs;
    ws_n = ws == W_IDLE ? (bus.awvalid && bus.wvalid ? W_ACK : W_IDLE) :
           ws == W_ACK  ? W_RESP : (bus.bready ? W_IDLE : W_RESP);
    rs_n = rs == R_IDLE ? (bus.arvalid ? R_ACK : R_IDLE) :
           rs == R_ACK  ? R_DATA : (bus.rready ? R_IDLE : R_DATA);
    bus.awready = ws == W_ACK;
    bus.wready  = ws == W_ACK;
    bus.bvalid  = ws == W_RESP;
    bus.arready = rs == R_ACK;
    bus.rvalid  = rs == R_DATA;
  end
  assign bus.rresp = 2'b00;
  assign we = ws == W_ACK;
  assign re = rs == R_ACK;
  assign wsel = bus.awaddr[3:2];
  assign rsel = bus.araddr[3:2];
  // A full holding register still accepts a write if the master drains it on the same edge
  assign cmd_take = cmd_full && cmd_ready;
  assign cmd_wr = we && wsel == 2'd1 && |bus.wstrb[1:0];
  assign cmd_drop = cmd_wr && cmd_full && !cmd_ready;
  assign tx_take = tx_full && data_out_ready;
  assign tx_wr = we && wsel == 2'd2 && bus.wstrb[0];
  assign tx_drop = tx_wr && tx_full && !data_out_ready;
  assign rx_cap = data_in_valid && !rx_full;
  assign rx_pop = re && rsel == 2'd2 && rx_full;
  assign w1c = we && wsel == 2'd0 && bus.wstrb[0] && bus.wdata[3];
  assign cmd_valid = cmd_full;
  assign data_out_valid = tx_full;
  assign data_in_ready = !rx_full;
  assign status = {25'b0, rx_full, tx_full, cmd_full, sticky, bus_active, bus_control, busy};
  assign rd_mux = rsel == 2'd0 ? status :
                  rsel == 2'd2 ? {22'b0, rx_last, rx_full, rx_byte} :
                  rsel == 2'd3 ? {16'b0, prescale} : 32'b0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      {cmd_stop, cmd_write_multiple, cmd_write, cmd_read, cmd_start, cmd_address} <= '0;
      {data_out_last, data_out} <= '0;
      {rx_last, rx_byte} <= '0;
      {cmd_full, tx_full, rx_full, sticky} <= '0;
      prescale <= DEFAULT_PRESCALE;
      bus.bresp <= 2'b00;
      bus.rdata <= 32'b0;
    end else begin
      if (cmd_wr && !cmd_drop)
        {cmd_stop, cmd_write_multiple, cmd_write, cmd_read, cmd_start, cmd_address} <= {bus.wdata[12:8], bus.wdata[6:0]};
      cmd_full <= (cmd_wr && !cmd_drop) || (cmd_full && !cmd_take);
      if (tx_wr && !tx_drop)
        {data_out_last, data_out} <= {bus.wdata[9], bus.wdata[7:0]};
      tx_full <= (tx_wr && !tx_drop) || (tx_full && !tx_take);
      if (rx_cap)
        {rx_last, rx_byte} <= {data_in_last, data_in};
      rx_full <= rx_cap || (rx_full && !rx_pop);
      sticky <= missed_ack || (sticky && !w1c);
      if (we && wsel == 2'd3 && bus.wstrb[0])
        prescale[7:0] <= bus.wdata[7:0];
      if (we && wsel == 2'd3 && bus.wstrb[1])
        prescale[15:8] <= bus.wdata[15:8];
      if (we)
        bus.bresp <= cmd_drop || tx_drop ? 2'b10 : 2'b00;
      if (re)
        bus.rdata <= rd_mux;
    end
  end
endmodule
